// File: rtl/uart_tx_arbiter_if.sv
// Bundle between byte requesters, the arbiter and one uart_tx transmitter.
//   req_valid/req_data/req_ready : per-requester byte handshake (byte i at [8i+7:8i])
//   done                         : per-requester frame-complete pulse
//   tx_data/tx_start/tx_idle     : transmitter side
//   busy/grant_id                : arbiter status
// master = arbiter view, slave = client/transmitter view.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   done;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_idle;
  logic               busy;
  logic [ID_W-1:0]    grant_id;

  modport master (
    input  req_valid, req_data, tx_idle,
    output req_ready, done, tx_data, tx_start, busy, grant_id
  );

  modport slave (
    output req_valid, req_data, tx_idle,
    input  req_ready, done, tx_data, tx_start, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte requesters.
// Latches the winning byte onto tx_data, strobes tx_start for one cycle, follows
// tx_idle through the frame, pulses done for the owner, then holds off the next
// grant for GAP_CYCLES idle cycles.
//   clk, rst : clock and synchronous active-high reset
//   bus      : uart_tx_arbiter_if.master (requester handshake, transmitter, status)
module uart_tx_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int unsigned GAP_W = 8;

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state, state_d;
  logic [ID_W-1:0]  last, grant_id, winner;
  logic [7:0]       tx_data, win_data;
  logic [GAP_W-1:0] gap;
  logic             found, grant;
  logic [N_REQ-1:0] req_ready, done;

  // Round-robin pick: first valid index above last, otherwise first valid overall,
  // which equals a modulo search starting at last+1.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!found && bus.req_valid[i] && (ID_W'(i) > last)) begin
        found    = 1'b1;
        winner   = ID_W'(i);
        win_data = bus.req_data[8*i +: 8];
      end
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!found && bus.req_valid[i]) begin
        found    = 1'b1;
        winner   = ID_W'(i);
        win_data = bus.req_data[8*i +: 8];
      end
    end
  end

  // Next state plus the combinational handshake and completion pulses.
  always_comb begin
    state_d   = state;
    grant     = 1'b0;
    req_ready = '0;
    done      = '0;
    case (state)
      IDLE: begin
        if ((gap == '0) && bus.tx_idle && found) begin
          grant             = 1'b1;
          req_ready[winner] = 1'b1;
          state_d           = START;
        end
      end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (!bus.tx_idle) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.tx_idle) begin
          done[grant_id] = 1'b1;
          state_d        = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  // State, latched byte, grant bookkeeping and inter-frame gap counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_data  <= '0;
      grant_id <= '0;
      last     <= ID_W'(N_REQ - 1);
      gap      <= '0;
    end else begin
      state <= state_d;
      if (grant) begin
        tx_data  <= win_data;
        grant_id <= winner;
        last     <= winner;
      end
      if ((state == WAIT_DONE) && bus.tx_idle) begin
        gap <= GAP_W'(GAP_CYCLES);
      end else if (gap != '0) begin
        gap <= gap - GAP_W'(1);
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.done      = done;
  assign bus.tx_data   = tx_data;
  assign bus.tx_start  = (state == START);
  assign bus.busy      = (state != IDLE) || (gap != '0);
  assign bus.grant_id  = grant_id;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a GAP_CYCLES=0 instance driving a behavioural
// 10-cycles-per-bit uart_tx model, and a GAP_CYCLES=5 instance with a hand-driven
// tx_idle. Expected grants/bytes are queued at handshake and retired on done.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic stub_hold;
  logic uart_idle;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(4)) abus ();
  uart_tx_arbiter_if #(.N_REQ(4)) gbus ();

  uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (abus)
  );

  uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(5)) dut_gap (
    .clk (clk),
    .rst (rst),
    .bus (gbus)
  );

  // Behavioural uart_tx: latches tx_data on tx_start, 10 bits x 10 cycles, LSB first.
  logic       u_busy;
  logic [3:0] u_bit, u_sub;
  logic [9:0] u_sh, rx_frame;
  logic       line;

  assign line          = u_busy ? u_sh[u_bit] : 1'b1;
  assign uart_idle     = ~u_busy;
  assign abus.tx_idle  = stub_hold ? 1'b0 : uart_idle;

  always @(posedge clk) begin
    if (rst) begin
      u_busy <= 1'b0;
      u_bit  <= '0;
      u_sub  <= '0;
    end else if (!u_busy) begin
      if (abus.tx_start) begin
        u_busy   <= 1'b1;
        u_sh     <= {1'b1, abus.tx_data, 1'b0};
        u_bit    <= '0;
        u_sub    <= '0;
        rx_frame <= '0;
      end
    end else begin
      if (u_sub == 4'd5) rx_frame[u_bit] <= line;
      if (u_sub == 4'd9) begin
        u_sub <= '0;
        if (u_bit == 4'd9) u_busy <= 1'b0;
        else u_bit <= u_bit + 4'd1;
      end else begin
        u_sub <= u_sub + 4'd1;
      end
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          exp_id;
    logic [7:0]  exp_data;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  localparam int NV = 8;
  vec_t vecs [NV];
  exp_t sb_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Checks the current cycle first so a same-cycle handshake is not missed.
  task automatic wait_ready(input int budget, output logic seen);
    seen = 1'b0;
    #1;
    if (|abus.req_ready) seen = 1'b1;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (|abus.req_ready) seen = 1'b1;
    end
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && sb_q.size() != 0; n++) @(negedge clk);
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  // Retires one queued expectation per done pulse.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (|abus.done) begin
        if (sb_q.size() == 0) begin
          check("done_unexpected", 32'(abus.done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("done_mask", 32'(abus.done), 32'(4'b1 << e.id));
          check("done_grant_id", 32'(abus.grant_id), 32'(e.id));
          check("done_tx_data", 32'(abus.tx_data), 32'(e.data));
          check("line_frame", 32'(rx_frame), 32'({1'b1, e.data, 1'b0}));
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   bad, n, busy_err;

    vecs[0] = '{4'b0001, 32'h443322A5, 0, 8'hA5};
    vecs[1] = '{4'b1111, 32'h44332211, 1, 8'h22};
    vecs[2] = '{4'b1111, 32'h44332211, 2, 8'h33};
    vecs[3] = '{4'b1111, 32'h44332211, 3, 8'h44};
    vecs[4] = '{4'b1111, 32'h44332211, 0, 8'h11};
    vecs[5] = '{4'b0100, 32'h44332211, 2, 8'h33};
    vecs[6] = '{4'b0101, 32'h44332211, 0, 8'h11};
    vecs[7] = '{4'b0101, 32'h44332211, 2, 8'h33};

    rst            = 1'b1;
    stub_hold      = 1'b0;
    abus.req_valid = '0;
    abus.req_data  = '0;
    gbus.req_valid = '0;
    gbus.req_data  = '0;
    gbus.tx_idle   = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({abus.tx_data, abus.grant_id, abus.tx_start, abus.busy,
                                abus.req_ready, abus.done}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table: single request, continuous round-robin, then fairness.
    for (int i = 0; i < NV; i++) begin
      abus.req_valid = vecs[i].valid;
      abus.req_data  = vecs[i].data;
      wait_ready(400, seen);
      if (!seen) begin
        check($sformatf("ready_timeout[%0d]", i), 32'd0, 32'd1);
      end else begin
        check($sformatf("req_ready[%0d]", i), 32'(abus.req_ready), 32'(4'b1 << vecs[i].exp_id));
        sb_q.push_back('{vecs[i].exp_id, vecs[i].exp_data});
        @(negedge clk);
        check($sformatf("tx_start[%0d]", i), 32'(abus.tx_start), 32'd1);
        check($sformatf("tx_data[%0d]", i), 32'(abus.tx_data), 32'(vecs[i].exp_data));
        check($sformatf("grant_id[%0d]", i), 32'(abus.grant_id), 32'(vecs[i].exp_id));
        @(negedge clk);
        check($sformatf("start_one_cycle[%0d]", i), 32'(abus.tx_start), 32'd0);
      end
    end
    abus.req_valid = '0;
    drain(400);

    // tx_idle held low while idle: no grant, no start; release grants requester 3.
    repeat (3) @(negedge clk);
    stub_hold      = 1'b1;
    abus.req_valid = 4'b1000;
    abus.req_data  = 32'hC3000000;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((abus.req_ready != '0) || abus.tx_start || abus.busy) bad++;
    end
    check("stub_hold_no_grant", 32'(bad), 32'd0);
    stub_hold = 1'b0;
    wait_ready(20, seen);
    check("stub_release_ready", 32'(abus.req_ready), 32'h8);
    if (seen) sb_q.push_back('{3, 8'hC3});
    @(negedge clk);
    abus.req_valid = '0;
    drain(400);

    // Reset mid-frame after a grant to requester 1: pointer must return to N_REQ-1.
    abus.req_valid = 4'b0010;
    abus.req_data  = 32'h00005A00;
    wait_ready(20, seen);
    check("pre_reset_ready", 32'(abus.req_ready), 32'h2);
    @(negedge clk);
    abus.req_valid = '0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midframe_reset_outputs", 32'({abus.tx_data, abus.grant_id, abus.tx_start, abus.busy,
                                         abus.req_ready, abus.done}), 32'd0);
    bad = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (|abus.done) bad++;
    end
    check("no_done_after_reset", 32'(bad), 32'd0);
    abus.req_valid = 4'b1001;
    abus.req_data  = 32'h7E000081;
    wait_ready(20, seen);
    check("post_reset_ready", 32'(abus.req_ready), 32'h1);
    if (seen) sb_q.push_back('{0, 8'h81});
    @(negedge clk);
    abus.req_valid = '0;
    drain(400);

    // GAP_CYCLES=5 instance with hand-driven tx_idle.
    gbus.req_valid = 4'b0001;
    gbus.req_data  = 32'h00005542;
    #1;
    check("gap_first_ready", 32'(gbus.req_ready), 32'h1);
    @(negedge clk);
    check("gap_tx_start", 32'(gbus.tx_start), 32'd1);
    gbus.tx_idle   = 1'b0;
    gbus.req_valid = 4'b0010;
    repeat (5) @(negedge clk);
    check("gap_in_frame", 32'({gbus.busy, gbus.done, gbus.req_ready}), 32'h100);
    gbus.tx_idle = 1'b1;
    #1;
    check("gap_done", 32'(gbus.done), 32'h1);
    n = 0;
    busy_err = 0;
    for (int k = 1; k <= 30 && n == 0; k++) begin
      @(negedge clk);
      if (|gbus.req_ready) n = k;
      else if (!gbus.busy) busy_err++;
    end
    check("gap_latency", 32'(n), 32'd6);
    check("gap_busy", 32'(busy_err), 32'd0);
    check("gap_next_ready", 32'(gbus.req_ready), 32'h2);
    @(negedge clk);
    gbus.req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
